// File: rtl/dbgu_pkg.sv
// Shared constants for the UART debug command engine: command/response codes,
// FSM state encoding and small width/byte helpers.
package dbgu_pkg;

    localparam logic [7:0] CMD_SET_ADDR = 8'h01;
    localparam logic [7:0] CMD_WRITE    = 8'h02;
    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] CMD_BURST    = 8'h04;

    localparam logic [7:0] RSP_ACK = 8'hAA;
    localparam logic [7:0] RSP_NAK = 8'hEE;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ARGS = 3'd1;
    localparam state_t ST_MEM  = 3'd2;
    localparam state_t ST_TXD  = 3'd3;
    localparam state_t ST_RESP = 3'd4;

    // Byte-index width able to count 0..nb (one past the last lane).
    function automatic int idx_w(input int nb);
        return $clog2(nb) + 1;
    endfunction

    function automatic logic [7:0] byte_lane(input logic [63:0] w, input int i);
        return w[i*8 +: 8];
    endfunction

endpackage

// File: rtl/dbgu_if.sv
// Byte stream (UART side) and memory bus signals of the debug engine.
interface dbgu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;
    logic              busy;

    modport slave (
        input  rx_data, rx_valid, tx_ready, mem_rdata, mem_rdy,
        output rx_ready, tx_data, tx_valid, mem_adr, mem_wdata, mem_we, mem_re, busy
    );

    modport master (
        output rx_data, rx_valid, tx_ready, mem_rdata, mem_rdy,
        input  rx_ready, tx_data, tx_valid, mem_adr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/dbgu_shreg.sv
// Byte-lane assembly register: gathers little-endian bytes into a word (i_wr)
// or holds a loaded word while a byte index walks its lanes (i_adv).
module dbgu_shreg
    import dbgu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clr,
    input  logic                     i_load,
    input  logic                     i_wr,
    input  logic                     i_adv,
    input  logic [W-1:0]             i_word,
    input  logic [7:0]               i_byte,
    output logic [W-1:0]             o_word,
    output logic [idx_w(W/8)-1:0]    o_idx
);
    localparam int NB = W / 8;
    localparam int IW = idx_w(NB);

    logic [W-1:0]  r_word;
    logic [IW-1:0] r_idx;

    // NOTE: non-blocking (<=) for every flop so all updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (r_idx == IW'(i)) r_word[i*8 +: 8] <= i_byte;
            end
            r_idx <= r_idx + 1'b1;
        end else if (i_adv) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_word = r_word;
    assign o_idx  = r_idx;
endmodule

// File: rtl/dbgu_core.sv
// UART debug command engine: decodes host bytes into pointer loads and single
// or burst word accesses at an auto-incrementing pointer; NAKs unknown bytes.
module dbgu_core
    import dbgu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic   clk,
    input logic   reset,
    dbgu_if.slave bus
);
    localparam int NB_A  = ADDR_W / 8;
    localparam int NB_D  = DATA_W / 8;
    localparam int ARG_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int IW_A  = idx_w(ARG_W / 8);
    localparam int IW_D  = idx_w(NB_D);
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

    state_t            r_state;
    logic [7:0]        r_cmd;
    logic [7:0]        r_rsp;
    logic [ADDR_W-1:0] r_ptr;
    logic [8:0]        r_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_re;
    logic              r_we;

    logic              w_rx_fire;
    logic              w_tx_fire;
    logic              w_arg_last;
    logic              w_rd_last;
    logic [IW_A-1:0]   w_nargs;
    logic [IW_A-1:0]   w_arg_idx;
    logic [IW_D-1:0]   w_rd_idx;
    logic [ARG_W-1:0]  w_arg_word;
    logic [DATA_W-1:0] w_rd_word;

    assign bus.rx_ready  = (r_state == ST_IDLE) || (r_state == ST_ARGS);
    assign bus.tx_valid  = (r_state == ST_TXD) || (r_state == ST_RESP);
    assign bus.tx_data   = (r_state == ST_TXD) ? byte_lane(64'(w_rd_word), int'(w_rd_idx)) : r_rsp;
    assign bus.mem_adr   = r_ptr;
    assign bus.mem_wdata = w_arg_word[DATA_W-1:0];
    assign bus.mem_we    = r_we;
    assign bus.mem_re    = r_re;
    assign bus.busy      = (r_state != ST_IDLE);

    assign w_rx_fire = bus.rx_valid && bus.rx_ready;
    assign w_tx_fire = bus.tx_valid && bus.tx_ready;

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_nargs = IW_A'(1);
        case (r_cmd)
            CMD_SET_ADDR: w_nargs = IW_A'(NB_A);
            CMD_WRITE:    w_nargs = IW_A'(NB_D);
            default:      w_nargs = IW_A'(1);
        endcase
    end

    assign w_arg_last = (w_arg_idx == w_nargs - 1'b1);
    assign w_rd_last  = (w_rd_idx == IW_D'(NB_D - 1));

    dbgu_shreg #(.W(ARG_W)) u_arg (
        .clk    (clk),
        .reset  (reset),
        .i_clr  ((r_state == ST_IDLE) && w_rx_fire),
        .i_load (1'b0),
        .i_wr   ((r_state == ST_ARGS) && w_rx_fire),
        .i_adv  (1'b0),
        .i_word ('0),
        .i_byte (bus.rx_data),
        .o_word (w_arg_word),
        .o_idx  (w_arg_idx)
    );

    dbgu_shreg #(.W(DATA_W)) u_rd (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (1'b0),
        .i_load ((r_state == ST_MEM) && r_re && bus.mem_rdy),
        .i_wr   (1'b0),
        .i_adv  ((r_state == ST_TXD) && w_tx_fire),
        .i_word (bus.mem_rdata),
        .i_byte (8'd0),
        .o_word (w_rd_word),
        .o_idx  (w_rd_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_rsp   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_re    <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rx_fire) begin
                    r_cmd <= bus.rx_data;
                    r_tmo <= '0;
                    case (bus.rx_data)
                        CMD_SET_ADDR, CMD_WRITE, CMD_BURST: r_state <= ST_ARGS;
                        CMD_READ: begin
                            r_cnt   <= 9'd1;
                            r_state <= ST_MEM;
                        end
                        default: begin
                            r_rsp   <= RSP_NAK;
                            r_state <= ST_RESP;
                        end
                    endcase
                end
                ST_ARGS: if (w_rx_fire) begin
                    r_tmo <= '0;
                    if (w_arg_last) begin
                        case (r_cmd)
                            CMD_SET_ADDR: begin
                                r_rsp   <= RSP_ACK;
                                r_state <= ST_RESP;
                            end
                            CMD_WRITE: r_state <= ST_MEM;
                            default: begin
                                r_cnt   <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                                r_state <= ST_MEM;
                            end
                        endcase
                    end
                end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
                // First MEM cycle raises the request; it drops on the edge that sees mem_rdy.
                ST_MEM: if (!r_re && !r_we) begin
                    if (r_cmd == CMD_WRITE) r_we <= 1'b1;
                    else                    r_re <= 1'b1;
                end else if (bus.mem_rdy) begin
                    r_re  <= 1'b0;
                    r_we  <= 1'b0;
                    r_ptr <= r_ptr + ADDR_W'(NB_D);
                    if (r_we) begin
                        r_rsp   <= RSP_ACK;
                        r_state <= ST_RESP;
                    end else begin
                        r_state <= ST_TXD;
                    end
                end
                ST_TXD: if (w_tx_fire && w_rd_last) begin
                    if (r_cnt == 9'd1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - 9'd1;
                        r_state <= ST_MEM;
                    end
                end
                ST_RESP: if (w_tx_fire) begin
                    if (r_cmd == CMD_SET_ADDR) r_ptr <= w_arg_word[ADDR_W-1:0];
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbgu_core.sv
// Scoreboard bench for dbgu_core: expected tx bytes and bus accesses are queued
// as commands are sent and popped when the DUT produces them.
module tb_dbgu_core;
    import dbgu_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 40;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdata;
    } bus_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dbgu_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dbgu_core #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_tx[$];
    bus_exp_t   exp_bus[$];

    logic [AW-1:0] m_ptr = '0;
    bit            rd_fixed = 1'b0;
    logic [DW-1:0] rd_fixed_val = '0;
    bit            txr_rand = 1'b0;
    int            rdy_wait = 0;
    int            acc_cnt = 0;
    int            first_cyc = 0;
    int            last_req_len = 0;
    int            last_acc = 0;
    int            tx_unstable = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] addr_data(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // Transmitter side: tx_ready either always high or randomly throttled.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = txr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // tx monitor: scoreboard pop plus hold-stability tracking.
    initial begin
        logic       hold_v;
        logic [7:0] hold_d;
        logic [7:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v && (!bus.tx_valid || bus.tx_data !== hold_d)) tx_unstable++;
                hold_v = bus.tx_valid && !bus.tx_ready;
                hold_d = bus.tx_data;
                if (bus.tx_valid && bus.tx_ready) begin
                    check("tx_pending", 64'(exp_tx.size() > 0), 64'd1);
                    if (exp_tx.size() > 0) begin
                        e = exp_tx.pop_front();
                        check("tx_byte", 64'(bus.tx_data), 64'(e));
                    end
                end
            end
        end
    end

    // Memory responder: mem_rdy after rdy_wait request cycles; checks each access.
    initial begin
        int            req_n;
        logic [AW-1:0] adr0;
        logic [DW-1:0] wd0;
        bit            unstable;
        bus_exp_t      b;
        req_n = 0;
        adr0 = '0;
        wd0 = '0;
        unstable = 1'b0;
        bus.mem_rdy = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset && (bus.mem_re || bus.mem_we)) begin
                if (req_n == 0) begin
                    adr0 = bus.mem_adr;
                    wd0 = bus.mem_wdata;
                    first_cyc = cyc;
                    unstable = 1'b0;
                end else if (bus.mem_adr !== adr0 || bus.mem_wdata !== wd0) begin
                    unstable = 1'b1;
                end
                req_n++;
                if (req_n > rdy_wait) begin
                    bus.mem_rdy = 1'b1;
                    bus.mem_rdata = rd_fixed ? rd_fixed_val : addr_data(bus.mem_adr);
                    last_req_len = req_n;
                    acc_cnt++;
                    check("bus_stable", 64'(unstable), 64'd0);
                    check("bus_pending", 64'(exp_bus.size() > 0), 64'd1);
                    if (exp_bus.size() > 0) begin
                        b = exp_bus.pop_front();
                        check("bus_we", 64'(bus.mem_we), 64'(b.we));
                        check("bus_adr", 64'(bus.mem_adr), 64'(b.adr));
                        if (b.we) check("bus_wdata", 64'(bus.mem_wdata), 64'(b.wdata));
                    end
                end else begin
                    bus.mem_rdy = 1'b0;
                end
            end else begin
                bus.mem_rdy = 1'b0;
                req_n = 0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) check("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic exp_word(input logic [DW-1:0] w);
        for (int i = 0; i < DW / 8; i++) exp_tx.push_back(w[i*8 +: 8]);
    endtask

    task automatic exp_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_exp_t e;
        e.we = we;
        e.adr = a;
        e.wdata = d;
        exp_bus.push_back(e);
    endtask

    task automatic cmd_set_addr(input logic [AW-1:0] a);
        exp_tx.push_back(RSP_ACK);
        send_byte(CMD_SET_ADDR);
        for (int i = 0; i < AW / 8; i++) send_byte(a[i*8 +: 8]);
        m_ptr = a;
    endtask

    task automatic cmd_read();
        exp_acc(1'b0, m_ptr, '0);
        exp_word(rd_fixed ? rd_fixed_val : addr_data(m_ptr));
        m_ptr = m_ptr + AW'(DW / 8);
        send_byte(CMD_READ);
    endtask

    task automatic cmd_write(input logic [DW-1:0] d);
        exp_acc(1'b1, m_ptr, d);
        exp_tx.push_back(RSP_ACK);
        m_ptr = m_ptr + AW'(DW / 8);
        send_byte(CMD_WRITE);
        for (int i = 0; i < DW / 8; i++) send_byte(d[i*8 +: 8]);
    endtask

    task automatic cmd_burst(input logic [7:0] n);
        int cnt;
        cnt = (n == 8'd0) ? 256 : int'(n);
        for (int k = 0; k < cnt; k++) begin
            exp_acc(1'b0, m_ptr, '0);
            exp_word(addr_data(m_ptr));
            m_ptr = m_ptr + AW'(DW / 8);
        end
        send_byte(CMD_BURST);
        send_byte(n);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || bus.busy) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("drain_tx", 64'(exp_tx.size()), 64'd0);
        check("drain_bus", 64'(exp_bus.size()), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
        check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_re", 64'(bus.mem_re), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_tx_data", 64'(bus.tx_data), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_mem_adr", 64'(bus.mem_adr), 64'd0);
        reset = 1'b0;

        // Unknown command 0x00 with pointer preset: single NAK, no bus access.
        cmd_set_addr(32'h0002_0000);
        wait_idle();
        n0 = acc_cnt;
        exp_tx.push_back(RSP_NAK);
        send_byte(8'h00);
        @(negedge clk);
        check("nak_latency", 64'(bus.tx_valid), 64'd1);
        wait_idle();
        check("nak_no_bus", 64'(acc_cnt - n0), 64'd0);

        // SET_ADDR then READ of a fixed word; the pointer must be untouched by the NAK.
        cmd_set_addr(32'h0002_0000);
        wait_idle();
        rd_fixed = 1'b1;
        rd_fixed_val = 32'hDEAD_BEEF;
        cmd_read();
        wait_idle();
        rd_fixed = 1'b0;
        check("read_latency", 64'(first_cyc - last_acc), 64'd1);

        // WRITE with a slow bus: request held for 11 cycles.
        rdy_wait = 10;
        cmd_write(32'h1234_5678);
        wait_idle();
        rdy_wait = 0;
        check("write_req_len", 64'(last_req_len), 64'd11);
        check("write_latency", 64'(first_cyc - last_acc), 64'd1);
        cmd_read();
        wait_idle();
        check("zero_wait_len", 64'(last_req_len), 64'd1);

        // Burst across the address wrap, then a read proving the final pointer.
        cmd_set_addr(32'hFFFF_FFFC);
        wait_idle();
        txr_rand = 1'b1;
        cmd_burst(8'd2);
        wait_idle();
        cmd_read();
        wait_idle();
        cmd_burst(8'd0);
        wait_idle();
        txr_rand = 1'b0;
        check("tx_hold_stable", 64'(tx_unstable), 64'd0);

        // Stalled SET_ADDR times out silently; the pointer keeps its value.
        n0 = acc_cnt;
        send_byte(CMD_SET_ADDR);
        send_byte(8'h55);
        send_byte(8'h66);
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        check("tmo_busy_before", 64'(bus.busy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("tmo_busy_after", 64'(bus.busy), 64'd0);
        check("tmo_no_bus", 64'(acc_cnt - n0), 64'd0);
        cmd_read();
        wait_idle();

        // Reset while a read request is pending.
        rdy_wait = 1000;
        send_byte(CMD_READ);
        n = 0;
        while (!bus.mem_re && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("re_pending", 64'(bus.mem_re), 64'd1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rr_mem_re", 64'(bus.mem_re), 64'd0);
        check("rr_mem_we", 64'(bus.mem_we), 64'd0);
        check("rr_rx_ready", 64'(bus.rx_ready), 64'd1);
        check("rr_tx_valid", 64'(bus.tx_valid), 64'd0);
        check("rr_busy", 64'(bus.busy), 64'd0);
        check("rr_mem_adr", 64'(bus.mem_adr), 64'd0);
        check("rr_tx_data", 64'(bus.tx_data), 64'd0);
        check("rr_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        rdy_wait = 0;
        m_ptr = '0;
        cmd_read();
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
